// File: rtl/jtframe_zxdos_joyser.sv
// jtframe_zxdos_joyser: serial joystick reader for the ZXDOS parallel-in/serial-out chain
// Ports: clk, rst (async, active high); scan_en allows new frames; joy_clk/joy_load drive the
// chain and joy_data is its active-low serial output; joystick1/joystick2 are active-high words;
// frame_done pulses once per frame; busy is high outside IDLE.
module jtframe_zxdos_joyser #(
    parameter int DIV      = 8,
    parameter int JOYW     = 12,
    parameter bit DEBOUNCE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            scan_en,
    output logic            joy_clk,
    output logic            joy_load,
    input  logic            joy_data,
    output logic [JOYW-1:0] joystick1,
    output logic [JOYW-1:0] joystick2,
    output logic            frame_done,
    output logic            busy
);
    localparam int N  = 2 * JOYW;
    localparam int NW = $clog2(N);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
    state_t        state, state_n;
    logic [7:0]    cnt;
    logic [NW-1:0] n;
    logic [N-1:0]  stream, prev;
    logic          tick, last;
    assign tick = cnt == 8'(DIV - 1);
    assign last = n == NW'(N - 1);
    assign busy = state != IDLE;
    // DONE is the only state that does not wait for a tick
    always_comb begin
        state_n = state;
        state_n = state == DONE  ? IDLE :
                  !tick          ? state :
                  state == IDLE  ? (scan_en ? LOAD : IDLE) :
                  state == LOAD  ? SHIFT :
                  (joy_clk && last) ? DONE : SHIFT;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            n          <= '0;
            stream     <= '0;
            prev       <= '1;
            joy_clk    <= 1'b0;
            joy_load   <= 1'b1;
            joystick1  <= '0;
            joystick2  <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= tick ? 8'd0 : cnt + 8'd1;
            frame_done <= state == DONE;
            if (tick && state == IDLE && scan_en) joy_load <= 1'b0;
            if (tick && state == LOAD) joy_load <= 1'b1;
            // sample while the clock is low so bit 0 is the value right after the load
            if (tick && state == SHIFT) begin
                joy_clk <= ~joy_clk;
                if (!joy_clk) stream[n] <= joy_data;
                else if (!last) n <= n + 1'b1;
            end
            if (state == DONE) begin
                if (!DEBOUNCE || stream == prev) {joystick2, joystick1} <= ~stream;
                prev <= stream;
                n    <= '0;
            end
        end
    end
endmodule

// File: tb/tb_jtframe_zxdos_joyser.sv
// tb_jtframe_zxdos_joyser: bench for the serial joystick reader, debounced and raw variants
module tb_jtframe_zxdos_joyser;
    localparam int DIV = 8, JOYW = 12, N = 2 * JOYW;
    logic clk = 0, rst = 1, scan_en = 0, jc_q = 0;
    logic jclk_a, jload_a, fd_a, busy_a, jclk_b, jload_b, fd_b, busy_b, joy_data;
    logic [JOYW-1:0] j1_a, j2_a, j1_b, j2_b, e1_a, e2_a, e1_b, e2_b;
    logic [N-1:0] pattern = '1, chain = '1, prev_m;
    int errs = 0, checks = 0;

    always #5 clk = ~clk;

    jtframe_zxdos_joyser #(.DIV(DIV), .JOYW(JOYW), .DEBOUNCE(1)) dut_a (
        .clk(clk), .rst(rst), .scan_en(scan_en), .joy_clk(jclk_a), .joy_load(jload_a),
        .joy_data(joy_data), .joystick1(j1_a), .joystick2(j2_a), .frame_done(fd_a), .busy(busy_a));
    jtframe_zxdos_joyser #(.DIV(DIV), .JOYW(JOYW), .DEBOUNCE(0)) dut_b (
        .clk(clk), .rst(rst), .scan_en(scan_en), .joy_clk(jclk_b), .joy_load(jload_b),
        .joy_data(joy_data), .joystick1(j1_b), .joystick2(j2_b), .frame_done(fd_b), .busy(busy_b));

    // shift chain: parallel load while load is low, shift toward bit 0 on each joy_clk rise
    assign joy_data = chain[0];
    always @(posedge clk) begin
        jc_q <= jclk_a;
        if (!jload_a) chain <= pattern;
        else if (jclk_a && !jc_q) chain <= {1'b1, chain[N-1:1]};
    end

    task automatic model_reset();
        prev_m = '1;
        {e1_a, e2_a, e1_b, e2_b} = '0;
    endtask

    task automatic model_frame(input logic [N-1:0] s);
        {e2_b, e1_b} = ~s;
        if (s == prev_m) {e2_a, e1_a} = ~s;
        prev_m = s;
    endtask

    task automatic wait_frame();
        int k;
        for (k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (fd_a) break;
        end
        checks++;
        if (k == 2000) begin
            errs++;
            $display("FAIL frame_timeout: no frame_done within 2000 clks");
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        rst = 1; scan_en = 0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({jclk_a, jload_a, fd_a, busy_a, j1_a, j2_a} !== {4'b0100, 24'h0}) begin
            errs++;
            $display("FAIL reset_a: got %b %h %h want 0100 000 000", {jclk_a, jload_a, fd_a, busy_a}, j1_a, j2_a);
        end
        checks++;
        if ({jclk_b, jload_b, fd_b, busy_b, j1_b, j2_b} !== {4'b0100, 24'h0}) begin
            errs++;
            $display("FAIL reset_b: got %b %h %h want 0100 000 000", {jclk_b, jload_b, fd_b, busy_b}, j1_b, j2_b);
        end
        rst = 0;
        repeat (40) begin
            @(negedge clk);
            if (!jload_a || busy_a) bad++;
        end
        checks++;
        if (bad != 0) begin
            errs++;
            $display("FAIL idle_hold: %0d active cycles with scan_en=0, want 0", bad);
        end
    endtask

    task automatic test_timing();
        int k, lowc = 0, cnt = 1, rises = 0, badph = 0;
        logic lv = 0;
        pattern = 24'h7FDFFE;
        scan_en = 1;
        for (k = 0; k < 50 && jload_a; k++) @(negedge clk);
        while (!jload_a && lowc < 100) begin
            lowc++;
            @(negedge clk);
        end
        for (k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (fd_a) break;
            if (jclk_a === lv) cnt++;
            else begin
                if (cnt != DIV) badph++;
                if (jclk_a) rises++;
                lv = jclk_a;
                cnt = 1;
            end
        end
        checks++;
        if (lowc != DIV) begin errs++; $display("FAIL load_width: got %0d want %0d", lowc, DIV); end
        checks++;
        if (rises != N) begin errs++; $display("FAIL clk_rises: got %0d want %0d", rises, N); end
        checks++;
        if (badph != 0) begin errs++; $display("FAIL clk_phase: %0d phases not %0d clks", badph, DIV); end
        checks++;
        if ({fd_a, fd_b} !== 2'b11) begin errs++; $display("FAIL frame_done: got %b want 11", {fd_a, fd_b}); end
        model_frame(pattern);
        checks++;
        if ({j1_a, j2_a, j1_b, j2_b} !== {e1_a, e2_a, e1_b, e2_b}) begin
            errs++;
            $display("FAIL first_frame: got %h want %h", {j1_a, j2_a, j1_b, j2_b}, {e1_a, e2_a, e1_b, e2_b});
        end
        checks++;
        if ({j1_b, j2_b, j1_a, j2_a} !== {12'h001, 12'h802, 24'h0}) begin
            errs++;
            $display("FAIL first_frame_const: got %h want 001802000000", {j1_b, j2_b, j1_a, j2_a});
        end
        @(negedge clk);
        checks++;
        if (fd_a !== 1'b0) begin errs++; $display("FAIL done_pulse: got %b want 0", fd_a); end
    endtask

    task automatic test_debounce();
        wait_frame();
        model_frame(pattern);
        checks++;
        if ({j1_a, j2_a} !== {12'h001, 12'h802}) begin
            errs++;
            $display("FAIL debounce_second: got %h want 001802", {j1_a, j2_a});
        end
        pattern = 24'h7FDFFF;
        wait_frame();
        model_frame(pattern);
        checks++;
        if ({j1_a, j2_a, j1_b, j2_b} !== {24'h001802, 24'h000802}) begin
            errs++;
            $display("FAIL debounce_glitch: got %h want 001802000802", {j1_a, j2_a, j1_b, j2_b});
        end
        pattern = 24'h7FDFFE;
        wait_frame();
        model_frame(pattern);
        checks++;
        if ({j1_a, j2_a, j1_b, j2_b} !== {e1_a, e2_a, e1_b, e2_b}) begin
            errs++;
            $display("FAIL debounce_return: got %h want %h", {j1_a, j2_a, j1_b, j2_b}, {e1_a, e2_a, e1_b, e2_b});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(1) == 1) pattern = N'($urandom);
            wait_frame();
            model_frame(pattern);
            checks++;
            if ({j1_a, j2_a, j1_b, j2_b} !== {e1_a, e2_a, e1_b, e2_b}) begin
                errs++;
                $display("FAIL random_%0d: got %h want %h", i, {j1_a, j2_a, j1_b, j2_b}, {e1_a, e2_a, e1_b, e2_b});
            end
        end
    endtask

    task automatic test_reset_mid();
        int k, r = 0, lowc = 0;
        logic pc = 0;
        for (k = 0; k < 2000 && r < 10; k++) begin
            @(negedge clk);
            if (jclk_a && !pc) r++;
            pc = jclk_a;
        end
        for (k = 0; k < 100 && jclk_a; k++) @(negedge clk);
        checks++;
        if (r != 10 || !busy_a) begin errs++; $display("FAIL mid_reach: rises %0d busy %b want 10 1", r, busy_a); end
        repeat (2) @(negedge clk);
        #3 rst = 1;
        #1;
        checks++;
        if ({jclk_a, jload_a, busy_a, j1_a, j2_a, j1_b, j2_b} !== {3'b010, 48'h0}) begin
            errs++;
            $display("FAIL async_reset: got %b %h want 010 0", {jclk_a, jload_a, busy_a}, {j1_a, j2_a, j1_b, j2_b});
        end
        model_reset();
        pattern = N'($urandom);
        @(negedge clk);
        rst = 0;
        for (k = 0; k < 50 && jload_a; k++) @(negedge clk);
        while (!jload_a && lowc < 100) begin
            lowc++;
            @(negedge clk);
        end
        checks++;
        if (lowc != DIV) begin errs++; $display("FAIL reload_width: got %0d want %0d", lowc, DIV); end
        for (int i = 0; i < 2; i++) begin
            wait_frame();
            model_frame(pattern);
            checks++;
            if ({j1_a, j2_a, j1_b, j2_b} !== {e1_a, e2_a, e1_b, e2_b}) begin
                errs++;
                $display("FAIL after_reset_%0d: got %h want %h", i, {j1_a, j2_a, j1_b, j2_b}, {e1_a, e2_a, e1_b, e2_b});
            end
        end
    endtask

    task automatic test_scan_en();
        int k, bad = 0;
        for (k = 0; k < 50 && jload_a; k++) @(negedge clk);
        repeat (40) @(negedge clk);
        scan_en = 0;
        wait_frame();
        model_frame(pattern);
        checks++;
        if ({j1_a, j2_a, j1_b, j2_b} !== {e1_a, e2_a, e1_b, e2_b}) begin
            errs++;
            $display("FAIL scan_drop_frame: got %h want %h", {j1_a, j2_a, j1_b, j2_b}, {e1_a, e2_a, e1_b, e2_b});
        end
        pattern = N'($urandom);
        repeat (300) begin
            @(negedge clk);
            if (!jload_a || busy_a || fd_a) bad++;
        end
        checks++;
        if (bad != 0) begin errs++; $display("FAIL scan_idle: %0d active cycles want 0", bad); end
        checks++;
        if ({j1_a, j2_a, j1_b, j2_b} !== {e1_a, e2_a, e1_b, e2_b}) begin
            errs++;
            $display("FAIL scan_hold: got %h want %h", {j1_a, j2_a, j1_b, j2_b}, {e1_a, e2_a, e1_b, e2_b});
        end
        scan_en = 1;
        for (k = 1; k <= DIV + 4; k++) begin
            @(negedge clk);
            if (!jload_a) break;
        end
        checks++;
        if (k > DIV) begin errs++; $display("FAIL scan_restart: load after %0d clks want <= %0d", k, DIV); end
        wait_frame();
        model_frame(pattern);
        checks++;
        if ({j1_a, j2_a, j1_b, j2_b} !== {e1_a, e2_a, e1_b, e2_b}) begin
            errs++;
            $display("FAIL scan_resume: got %h want %h", {j1_a, j2_a, j1_b, j2_b}, {e1_a, e2_a, e1_b, e2_b});
        end
    endtask

    task automatic test_all_ones();
        pattern = '1;
        for (int i = 0; i < 3; i++) begin
            wait_frame();
            model_frame(pattern);
            checks++;
            if ({j1_a, j2_a, j1_b, j2_b} !== {e1_a, e2_a, e1_b, e2_b}) begin
                errs++;
                $display("FAIL ones_%0d: got %h want %h", i, {j1_a, j2_a, j1_b, j2_b}, {e1_a, e2_a, e1_b, e2_b});
            end
        end
        checks++;
        if ({j1_a, j2_a, j1_b, j2_b} !== 48'h0) begin
            errs++;
            $display("FAIL ones_zero: got %h want 0", {j1_a, j2_a, j1_b, j2_b});
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_debounce();
        test_random();
        test_reset_mid();
        test_scan_en();
        test_all_ones();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/jtframe_zxdos_joyser.md
Name: jtframe_zxdos_joyser

Overview:
- Serial joystick reader for the ZXDOS board. It sits directly upstream of the ZXDOS base, which consumes joystick1/joystick2.
- Drives the board's parallel-in/serial-out shift chain through JOY_LOAD and JOY_CLK, and samples JOY_DATA.
- Splits each frame into two active-high joystick words.
- Optionally debounces, so an output word only changes after two consecutive identical frames.

Parameters:
- DIV, 8: clk cycles per tick. A tick is half a JOY_CLK period. Legal range 2..255.
- JOYW, 12: bits per joystick.
- DEBOUNCE, 1: 1 = update outputs only when two consecutive frames match; 0 = update every frame.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- scan_en  in  1  allow new frames to start; 0 holds the block in IDLE after the current frame
- joy_clk  out  1  shift clock to the chain
- joy_load  out  1  parallel load strobe, active low
- joy_data  in  1  serial data from the chain, active low per button
- joystick1  out  JOYW  player 1 buttons, active high
- joystick2  out  JOYW  player 2 buttons, active high
- frame_done  out  1  one-clk pulse at the end of every frame
- busy  out  1  high while state is not IDLE

Behaviour:
- Reset, asynchronous and applied immediately, including mid-frame:
  - joy_clk=0, joy_load=1, joystick1=joystick2=0, frame_done=0, busy=0
  - state=IDLE, prescaler=0, bit counter=0, previous-frame register=all ones (no buttons pressed)
  - any partially shifted frame is discarded
- Prescaler:
  - counts 0..DIV-1; tick is asserted when count==DIV-1, then count wraps to 0
  - runs freely in every state
- State machine (IDLE, LOAD, SHIFT, DONE); all transitions happen on tick, except DONE, which lasts exactly one clk:
  - IDLE: on tick with scan_en=1, set joy_load=0 and go to LOAD.
  - LOAD: on the next tick, set joy_load=1 and go to SHIFT. joy_load is therefore low for exactly DIV clk cycles. joy_clk stays 0 throughout.
  - SHIFT, tick with joy_clk=0: capture joy_data as stream bit n (n = bit counter), then set joy_clk=1. Capture happens before the rising edge, so bit 0 is the value presented right after the load.
  - SHIFT, tick with joy_clk=1: set joy_clk=0 and increment n. When n reaches 2*JOYW-1, go to DONE instead of incrementing.
  - DONE, one clk:
    - form word W = ~stream (invert to active high)
    - stream bits 0..JOYW-1 map to joystick1[0..JOYW-1]
    - stream bits JOYW..2*JOYW-1 map to joystick2[0..JOYW-1]
    - if DEBOUNCE=0, or the raw stream equals the previous-frame register, load the outputs from W
    - store the stream into the previous-frame register
    - pulse frame_done for one clk, reset n=0, go to IDLE
- Each frame produces exactly 2*JOYW rising edges of joy_clk. joy_clk high and low phases are each DIV clk cycles.
- Outputs change only in the DONE cycle; they are registered, so new values are visible the clk after DONE.
- scan_en falling mid-frame has no effect until IDLE; the frame completes normally.
- If joy_data changes within a frame, only the value at each capture tick matters.

Test Plan:
- Reset, then release with scan_en=1 and DIV=8, JOYW=12 → joy_load low for exactly 8 clks; then 24 joy_clk rising edges, each high/low phase 8 clks; then one frame_done pulse.
- Chain model returns stream bit0=0 and bits 13,23=0, all others 1; DEBOUNCE=0 → after the first frame_done, joystick1=12'h001, joystick2=12'h802.
- Same pattern with DEBOUNCE=1 → outputs stay 0 after frame 1 and become 12'h001 / 12'h802 after frame 2. Then change bit 0 to 1 for one frame only → outputs do not change.
- Assert rst asynchronously during SHIFT at n=10 → joy_clk=0, joy_load=1 and outputs=0 the same cycle. After release, the next frame starts with a full 8-clk load pulse and the outputs match the new data.
- Drop scan_en mid-frame → that frame completes with frame_done; no further joy_load pulses; busy=0; outputs hold. Raise scan_en → a load occurs within DIV clks.
- All ones on joy_data for 3 frames → joystick1=joystick2=0, with frame_done pulsing once per frame.
